// File: rtl/mem_pkg.sv
// Shared types and helpers for dual_port_mem and its per-channel FSMs.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned MAX_LATENCY = 7;
    localparam int unsigned CNT_W       = 3;

    // Index width for a power-of-two depth.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_chan_fsm.sv
// One request/response channel: handshake, wait-state counter, hold register and err flag.
module mem_chan_fsm
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              is_write,
    input  logic              err_in,
    input  logic [DATA_W-1:0] rd_word,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] hold;
    logic              hold_err;
    logic              accept_c;
    logic [DATA_W-1:0] cap_c;

    assign accept_c = req & ready;
    // Write responses carry zero data.
    assign cap_c    = is_write ? '0 : rd_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hold     <= '0;
            hold_err <= 1'b0;
            ready    <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            case (state)
                // RESP accepts like IDLE so LATENCY=0 streams without bubbles.
                IDLE, RESP: begin
                    if (accept_c) begin
                        hold     <= cap_c;
                        hold_err <= err_in;
                        if (LATENCY == 0) begin
                            state  <= RESP;
                            ready  <= 1'b1;
                            rvalid <= 1'b1;
                            rdata  <= cap_c;
                            err    <= err_in;
                        end else begin
                            state <= WAIT;
                            ready <= 1'b0;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state  <= RESP;
                        ready  <= 1'b1;
                        rvalid <= 1'b1;
                        rdata  <= hold;
                        err    <= hold_err;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/dual_port_mem.sv
// Shared word array with a read-only fetch channel (I) and a read/write data channel (D).
// Optional BYTE_EN_EN macro adds d_be byte-lane write enables.
module dual_port_mem
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
`ifdef BYTE_EN_EN
    input  logic [DATA_W/8-1:0] d_be,
`endif
    output logic              i_err
);

    localparam int unsigned IDX_W = clog2(DEPTH);
    localparam int          NB    = int'(DATA_W / 8);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  i_idx_c, d_idx_c;
    logic              i_oob_c, d_oob_c;
    logic [DATA_W-1:0] i_word_c, d_word_c;
    logic              d_acc_c;

    // Word index wraps; any set bit above the index flags out-of-range.
    if (ADDR_W > IDX_W) begin : g_wide_addr
        assign i_idx_c = i_addr[IDX_W-1:0];
        assign d_idx_c = d_addr[IDX_W-1:0];
        assign i_oob_c = |i_addr[ADDR_W-1:IDX_W];
        assign d_oob_c = |d_addr[ADDR_W-1:IDX_W];
    end else begin : g_narrow_addr
        assign i_idx_c = IDX_W'(i_addr);
        assign d_idx_c = IDX_W'(d_addr);
        assign i_oob_c = 1'b0;
        assign d_oob_c = 1'b0;
    end

    // Reads see the array before this edge's write, giving read-first collisions.
    assign i_word_c = mem[i_idx_c];
    assign d_word_c = mem[d_idx_c];
    assign d_acc_c  = d_req & d_ready;

    always_ff @(posedge clk) begin
        if (rst_n && d_acc_c && d_we) begin
`ifdef BYTE_EN_EN
            for (int k = 0; k < NB; k++) begin
                if (d_be[k]) begin
                    mem[d_idx_c][8*k +: 8] <= d_wdata[8*k +: 8];
                end
            end
`else
            mem[d_idx_c] <= d_wdata;
`endif
        end
    end

    mem_chan_fsm #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) u_i_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (i_req),
        .is_write (1'b0),
        .err_in   (i_oob_c),
        .rd_word  (i_word_c),
        .ready    (i_ready),
        .rvalid   (i_rvalid),
        .rdata    (i_rdata),
        .err      (i_err)
    );

    mem_chan_fsm #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) u_d_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (d_req),
        .is_write (d_we),
        .err_in   (d_oob_c),
        .rd_word  (d_word_c),
        .ready    (d_ready),
        .rvalid   (d_rvalid),
        .rdata    (d_rdata),
        .err      (d_err)
    );

endmodule

// File: tb/tb_dual_port_mem.sv
// Bench for dual_port_mem: LATENCY=0 and LATENCY=3 instances against a cycle-level reference model.
`timescale 1ns/1ps
module tb_dual_port_mem;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 256;
`ifdef BYTE_EN_EN
    localparam logic [3:0] BE_FORCE = 4'h0;
`else
    localparam logic [3:0] BE_FORCE = 4'hF;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          i_req [2];
    logic [AW-1:0] i_addr [2];
    logic          d_req [2];
    logic          d_we [2];
    logic [AW-1:0] d_addr [2];
    logic [DW-1:0] d_wdata [2];
    logic [3:0]    d_be [2];

    logic          i_ready_w [2], i_rvalid_w [2], i_err_w [2];
    logic          d_ready_w [2], d_rvalid_w [2], d_err_w [2];
    logic [DW-1:0] i_rdata_w [2], d_rdata_w [2];

    int total = 0;
    int bad   = 0;

    dual_port_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ready(i_ready_w[0]),
        .i_rvalid(i_rvalid_w[0]), .i_rdata(i_rdata_w[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_ready(d_ready_w[0]), .d_rvalid(d_rvalid_w[0]), .d_rdata(d_rdata_w[0]),
        .d_err(d_err_w[0]),
`ifdef BYTE_EN_EN
        .d_be(d_be[0]),
`endif
        .i_err(i_err_w[0])
    );

    dual_port_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ready(i_ready_w[1]),
        .i_rvalid(i_rvalid_w[1]), .i_rdata(i_rdata_w[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_ready(d_ready_w[1]), .d_rvalid(d_rvalid_w[1]), .d_rdata(d_rdata_w[1]),
        .d_err(d_err_w[1]),
`ifdef BYTE_EN_EN
        .d_be(d_be[1]),
`endif
        .i_err(i_err_w[1])
    );

    // Reference model: [dut][channel], channel 0 = I, 1 = D.
    int            cyc = 0;
    logic [DW-1:0] mm [2][DEPTH];
    bit            p_v [2][2];
    int            p_due [2][2];
    logic [DW-1:0] p_data [2][2];
    bit            p_err [2][2];
    bit            e_ready [2][2], e_rvalid [2][2], e_err [2][2];
    logic [DW-1:0] e_rdata [2][2];
    bit            m_acc [2][2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic model_edge();
        logic [3:0] be;
        int unsigned ix;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            m_acc[d][0] = 1'b0;
            m_acc[d][1] = 1'b0;
            if (!rst_n) begin
                for (int c = 0; c < 2; c++) begin
                    p_v[d][c] = 1'b0; e_ready[d][c] = 1'b0; e_rvalid[d][c] = 1'b0;
                    e_rdata[d][c] = '0; e_err[d][c] = 1'b0;
                end
            end else begin
                if (i_req[d] && e_ready[d][0]) begin
                    ix = i_addr[d] % DEPTH;
                    m_acc[d][0] = 1'b1; p_v[d][0] = 1'b1; p_due[d][0] = cyc + lat_of(d);
                    p_data[d][0] = mm[d][ix]; p_err[d][0] = (i_addr[d] >= DEPTH);
                end
                if (d_req[d] && e_ready[d][1]) begin
                    ix = d_addr[d] % DEPTH;
                    m_acc[d][1] = 1'b1; p_v[d][1] = 1'b1; p_due[d][1] = cyc + lat_of(d);
                    p_err[d][1] = (d_addr[d] >= DEPTH);
                    if (d_we[d]) begin
                        p_data[d][1] = '0;
                        be = d_be[d] | BE_FORCE;
                        for (int k = 0; k < 4; k++)
                            if (be[k]) mm[d][ix][8*k +: 8] = d_wdata[d][8*k +: 8];
                    end else begin
                        p_data[d][1] = mm[d][ix];
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    e_rvalid[d][c] = 1'b0;
                    e_err[d][c] = 1'b0;
                    if (p_v[d][c] && p_due[d][c] == cyc) begin
                        e_rvalid[d][c] = 1'b1; e_rdata[d][c] = p_data[d][c];
                        e_err[d][c] = p_err[d][c]; p_v[d][c] = 1'b0;
                    end
                    e_ready[d][c] = !p_v[d][c];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            i_req[d] = 1'b0; i_addr[d] = '0; d_req[d] = 1'b0; d_we[d] = 1'b0;
            d_addr[d] = '0; d_wdata[d] = '0; d_be[d] = 4'hF;
        end
    endtask

    // Issues one I and/or D transaction on one DUT and collects its responses.
    task automatic xact(input int d, input bit do_i, input logic [AW-1:0] ia,
                        input bit do_d, input bit we, input logic [AW-1:0] da,
                        input logic [DW-1:0] wd, input logic [3:0] be,
                        output logic [DW-1:0] ird, output logic ierr,
                        output logic [DW-1:0] drd, output logic derr,
                        output int dlat, output int dlow, output bit timed_out);
        bit need_i, need_d;
        int acc;
        need_i = do_i; need_d = do_d; acc = 0;
        ird = '0; ierr = 1'b0; drd = '0; derr = 1'b0; dlat = -1; dlow = 0;
        i_req[d] = do_i; i_addr[d] = ia;
        d_req[d] = do_d; d_we[d] = we; d_addr[d] = da; d_wdata[d] = wd; d_be[d] = be;
        for (int n = 0; n < 32 && (need_i || need_d); n++) begin
            tick();
            if (m_acc[d][0]) i_req[d] = 1'b0;
            if (m_acc[d][1]) begin d_req[d] = 1'b0; acc = cyc; end
            if (d_ready_w[d] === 1'b0) dlow++;
            if (need_i && i_rvalid_w[d] === 1'b1) begin
                ird = i_rdata_w[d]; ierr = i_err_w[d]; need_i = 1'b0;
            end
            if (need_d && d_rvalid_w[d] === 1'b1) begin
                drd = d_rdata_w[d]; derr = d_err_w[d]; dlat = cyc - acc + 1; need_d = 1'b0;
            end
        end
        timed_out = need_i || need_d;
        i_req[d] = 1'b0; d_req[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            total++; if (i_ready_w[d] !== 1'b0) begin bad++; $display("FAIL rst_i_ready dut%0d got=%b want=0", d, i_ready_w[d]); end
            total++; if (d_ready_w[d] !== 1'b0) begin bad++; $display("FAIL rst_d_ready dut%0d got=%b want=0", d, d_ready_w[d]); end
            total++; if (i_rvalid_w[d] !== 1'b0 || d_rvalid_w[d] !== 1'b0) begin bad++; $display("FAIL rst_rvalid dut%0d got=%b%b want=00", d, i_rvalid_w[d], d_rvalid_w[d]); end
            total++; if (i_err_w[d] !== 1'b0 || d_err_w[d] !== 1'b0) begin bad++; $display("FAIL rst_err dut%0d got=%b%b want=00", d, i_err_w[d], d_err_w[d]); end
            total++; if (i_rdata_w[d] !== '0 || d_rdata_w[d] !== '0) begin bad++; $display("FAIL rst_rdata dut%0d got=%h/%h want=0", d, i_rdata_w[d], d_rdata_w[d]); end
        end
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            total++; if (i_ready_w[d] !== 1'b1 || d_ready_w[d] !== 1'b1) begin bad++; $display("FAIL post_rst_ready dut%0d got=%b%b want=11", d, i_ready_w[d], d_ready_w[d]); end
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] ird, drd; logic ierr, derr; int dlat, dlow; bit to; bit any_to;
        any_to = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < int'(DEPTH); a++) begin
                xact(d, 1'b0, '0, 1'b1, 1'b1, AW'(a), $urandom, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
                any_to |= to;
            end
        total++; if (any_to !== 1'b0) begin bad++; $display("FAIL fill_timeout got=%b want=0", any_to); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] ird, drd, want; logic ierr, derr; int dlat, dlow; bit to;
        for (int a = 0; a < 4; a++)
            xact(0, 1'b0, '0, 1'b1, 1'b1, AW'(a), 32'hA5A5_0001 + DW'(a), 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
        for (int a = 0; a < 4; a++) begin
            i_req[0] = 1'b1; i_addr[0] = AW'(a);
            tick();
            want = 32'hA5A5_0001 + DW'(a);
            total++; if (i_rvalid_w[0] !== 1'b1) begin bad++; $display("FAIL stream_rvalid beat%0d got=%b want=1", a, i_rvalid_w[0]); end
            total++; if (i_rdata_w[0] !== want) begin bad++; $display("FAIL stream_rdata beat%0d got=%h want=%h", a, i_rdata_w[0], want); end
            total++; if (i_ready_w[0] !== 1'b1) begin bad++; $display("FAIL stream_ready beat%0d got=%b want=1", a, i_ready_w[0]); end
        end
        i_req[0] = 1'b0;
        tick();
        total++; if (i_rvalid_w[0] !== 1'b0) begin bad++; $display("FAIL stream_end_rvalid got=%b want=0", i_rvalid_w[0]); end
    endtask

    task automatic test_latency();
        logic [DW-1:0] ird, drd; logic ierr, derr; int dlat, dlow, pulses; bit to;
        for (int d = 0; d < 2; d++) begin
            xact(d, 1'b0, '0, 1'b1, 1'b1, 32'd5, 32'h1234_5678, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
            xact(d, 1'b0, '0, 1'b1, 1'b0, 32'd5, '0, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
            total++; if (to !== 1'b0) begin bad++; $display("FAIL lat_timeout dut%0d got=%b want=0", d, to); end
            total++; if (drd !== 32'h1234_5678) begin bad++; $display("FAIL lat_rdata dut%0d got=%h want=12345678", d, drd); end
            total++; if (dlat != lat_of(d) + 1) begin bad++; $display("FAIL lat_cycles dut%0d got=%0d want=%0d", d, dlat, lat_of(d) + 1); end
            total++; if (dlow != lat_of(d)) begin bad++; $display("FAIL lat_ready_low dut%0d got=%0d want=%0d", d, dlow, lat_of(d)); end
            pulses = 0;
            for (int n = 0; n < 6; n++) begin tick(); if (d_rvalid_w[d] === 1'b1) pulses++; end
            total++; if (pulses != 0) begin bad++; $display("FAIL lat_extra_pulse dut%0d got=%0d want=0", d, pulses); end
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] ird, drd; logic ierr, derr; int dlat, dlow; bit to;
        for (int d = 0; d < 2; d++) begin
            xact(d, 1'b0, '0, 1'b1, 1'b1, 32'd7, 32'h7, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
            xact(d, 1'b1, 32'd7, 1'b1, 1'b1, 32'd7, 32'hDEAD_BEEF, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
            total++; if (ird !== 32'h7 || to !== 1'b0) begin bad++; $display("FAIL coll_old dut%0d got=%h want=00000007", d, ird); end
            total++; if (drd !== '0) begin bad++; $display("FAIL coll_wr_rdata dut%0d got=%h want=0", d, drd); end
            xact(d, 1'b1, 32'd7, 1'b0, 1'b0, '0, '0, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
            total++; if (ird !== 32'hDEAD_BEEF) begin bad++; $display("FAIL coll_new dut%0d got=%h want=deadbeef", d, ird); end
        end
        // D read on the edge right after its own write.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'd20; d_wdata[0] = 32'hC0FF_EE01; d_be[0] = 4'hF;
        tick();
        total++; if (d_rvalid_w[0] !== 1'b1 || d_rdata_w[0] !== '0) begin bad++; $display("FAIL raw_wr_resp got=%b/%h want=1/0", d_rvalid_w[0], d_rdata_w[0]); end
        d_we[0] = 1'b0;
        tick();
        d_req[0] = 1'b0;
        total++; if (d_rvalid_w[0] !== 1'b1 || d_rdata_w[0] !== 32'hC0FF_EE01) begin bad++; $display("FAIL raw_rd got=%b/%h want=1/c0ffee01", d_rvalid_w[0], d_rdata_w[0]); end
        tick();
    endtask

    task automatic test_oob();
        logic [DW-1:0] ird, drd; logic ierr, derr; int dlat, dlow; bit to;
        for (int d = 0; d < 2; d++) begin
            xact(d, 1'b1, 32'h105, 1'b1, 1'b0, 32'h105, '0, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
            total++; if (drd !== 32'h1234_5678 || derr !== 1'b1) begin bad++; $display("FAIL oob_d dut%0d got=%h/%b want=12345678/1", d, drd, derr); end
            total++; if (ird !== 32'h1234_5678 || ierr !== 1'b1) begin bad++; $display("FAIL oob_i dut%0d got=%h/%b want=12345678/1", d, ird, ierr); end
            xact(d, 1'b1, 32'h5, 1'b1, 1'b1, 32'hFF, 32'h0BAD_F00D, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
            total++; if (derr !== 1'b0 || ierr !== 1'b0 || to !== 1'b0) begin bad++; $display("FAIL inrange_err dut%0d got=%b%b want=00", d, ierr, derr); end
            xact(d, 1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FF0A, 32'h0000_AAAA, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
            total++; if (derr !== 1'b1 || drd !== '0) begin bad++; $display("FAIL oob_wr dut%0d got=%b/%h want=1/0", d, derr, drd); end
        end
    endtask

    task automatic test_byte_en();
        logic [DW-1:0] ird, drd, want; logic ierr, derr; int dlat, dlow; bit to;
`ifdef BYTE_EN_EN
        want = 32'h11BB_33DD;
`else
        want = 32'hAABB_CCDD;
`endif
        for (int d = 0; d < 2; d++) begin
            xact(d, 1'b0, '0, 1'b1, 1'b1, 32'd9, 32'h1122_3344, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
            xact(d, 1'b0, '0, 1'b1, 1'b1, 32'd9, 32'hAABB_CCDD, 4'b0101, ird, ierr, drd, derr, dlat, dlow, to);
            xact(d, 1'b1, 32'd9, 1'b0, 1'b0, '0, '0, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
            total++; if (ird !== want) begin bad++; $display("FAIL byte_en dut%0d got=%h want=%h", d, ird, want); end
        end
    endtask

    task automatic test_reset_midop();
        logic [DW-1:0] ird, drd; logic ierr, derr; int dlat, dlow, pulses; bit to;
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'd2; d_wdata[1] = 32'h55; d_be[1] = 4'hF;
        tick();
        d_req[1] = 1'b0;
        total++; if (d_ready_w[1] !== 1'b0) begin bad++; $display("FAIL midop_accept_ready got=%b want=0", d_ready_w[1]); end
        tick();
        rst_n = 1'b0;
        tick();
        total++; if (d_ready_w[1] !== 1'b0 || d_rvalid_w[1] !== 1'b0) begin bad++; $display("FAIL midop_in_reset got=%b%b want=00", d_ready_w[1], d_rvalid_w[1]); end
        rst_n = 1'b1;
        pulses = 0;
        tick();
        if (d_rvalid_w[1] === 1'b1) pulses++;
        total++; if (d_ready_w[1] !== 1'b1) begin bad++; $display("FAIL midop_ready_after got=%b want=1", d_ready_w[1]); end
        for (int n = 0; n < 5; n++) begin tick(); if (d_rvalid_w[1] === 1'b1) pulses++; end
        total++; if (pulses != 0) begin bad++; $display("FAIL midop_dropped got=%0d want=0", pulses); end
        xact(1, 1'b0, '0, 1'b1, 1'b0, 32'd2, '0, 4'hF, ird, ierr, drd, derr, dlat, dlow, to);
        total++; if (drd !== 32'h55) begin bad++; $display("FAIL midop_committed got=%h want=00000055", drd); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int d = 0; d < 2; d++) begin
                i_req[d]   = 1'($urandom_range(0, 1));
                i_addr[d]  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 511));
                d_req[d]   = 1'($urandom_range(0, 1));
                d_we[d]    = 1'($urandom_range(0, 1));
                d_addr[d]  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 511));
                d_wdata[d] = $urandom;
                d_be[d]    = 4'($urandom_range(0, 15));
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                total++; if (i_ready_w[d] !== e_ready[d][0] || d_ready_w[d] !== e_ready[d][1]) begin
                    bad++; $display("FAIL rnd_ready dut%0d cyc%0d got=%b%b want=%b%b", d, cyc, i_ready_w[d], d_ready_w[d], e_ready[d][0], e_ready[d][1]); end
                total++; if (i_rvalid_w[d] !== e_rvalid[d][0] || d_rvalid_w[d] !== e_rvalid[d][1]) begin
                    bad++; $display("FAIL rnd_rvalid dut%0d cyc%0d got=%b%b want=%b%b", d, cyc, i_rvalid_w[d], d_rvalid_w[d], e_rvalid[d][0], e_rvalid[d][1]); end
                if (e_rvalid[d][0]) begin
                    total++; if (i_rdata_w[d] !== e_rdata[d][0] || i_err_w[d] !== e_err[d][0]) begin
                        bad++; $display("FAIL rnd_i_resp dut%0d cyc%0d got=%h/%b want=%h/%b", d, cyc, i_rdata_w[d], i_err_w[d], e_rdata[d][0], e_err[d][0]); end
                end
                if (e_rvalid[d][1]) begin
                    total++; if (d_rdata_w[d] !== e_rdata[d][1] || d_err_w[d] !== e_err[d][1]) begin
                        bad++; $display("FAIL rnd_d_resp dut%0d cyc%0d got=%h/%b want=%h/%b", d, cyc, d_rdata_w[d], d_err_w[d], e_rdata[d][1], e_err[d][1]); end
                end
            end
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_fill();
        test_stream();
        test_latency();
        test_collision();
        test_oob();
        test_byte_en();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
